outmem_reader: RTL and testbench

- Reads the MAC array's result matrix back out of the output memory once a computation has finished.
- Operates as the read-side agent of the output-memory port: drives EN/RW/ADDR and consumes RDATA with 1-cycle read latency.
- Unpacks each 64-bit row word into 16-bit result elements and streams them on a valid/ready interface to the downstream consumer (host readback / checker).
- Flags the final element and pulses DONE when the matrix has been fully drained.

---
 rtl/outmem_pkg.sv | 34 +++
 rtl/outmem_reader_if.sv | 29 ++
 rtl/outmem_lane_mux.sv | 19 +
 rtl/outmem_reader.sv | 125 ++++++++++++
 tb/tb_outmem_reader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/outmem_pkg.sv
// Shared constants, state encoding and shape check for the output-memory reader.
package outmem_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int ADDR_W = 4;
  localparam int WORD_W = LANES * DATA_W;
  localparam int SEL_W  = 2;
  localparam int MNT_W  = 12;
  localparam int FLD_W  = 4;

  localparam int MNT_M_HI = 11;
  localparam int MNT_M_LO = 8;
  localparam int MNT_N_HI = 7;
  localparam int MNT_N_LO = 4;

  localparam logic RW_READ = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  // N beyond the lanes of one word cannot be served from a single row read.
  function automatic logic shape_invalid(input logic [FLD_W-1:0] m, input logic [FLD_W-1:0] n);
    logic [FLD_W-1:0] lanes_f;
    lanes_f = FLD_W'(LANES);
    return (m == '0) || (n == '0) || (n > lanes_f);
  endfunction

endpackage

// File: rtl/outmem_reader_if.sv
// Control, memory-port and stream signals between the reader and its environment.
interface outmem_reader_if;
  import outmem_pkg::*;

  logic [MNT_W-1:0]  MNT;
  logic              START;
  logic              BUSY;
  logic              EN_O;
  logic              RW_O;
  logic [ADDR_W-1:0] ADDR_O;
  logic [WORD_W-1:0] RDATA_O;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_LAST;
  logic              DONE;
  logic              ERR;

  modport master (
    input  MNT, START, RDATA_O, OUT_READY,
    output BUSY, EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_LAST, DONE, ERR
  );

  modport slave (
    output MNT, START, RDATA_O, OUT_READY,
    input  BUSY, EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_LAST, DONE, ERR
  );

endinterface

// File: rtl/outmem_lane_mux.sv
// Selects one DATA_W element out of a packed row word; lane 0 sits in the top bits.
module outmem_lane_mux
  import outmem_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = word_i[WORD_W-1-DATA_W*k -: DATA_W];
      end
    end
  end

endmodule

// File: rtl/outmem_reader.sv
// Drains an M x N result matrix from the output memory, one row word per read,
// and streams its elements on a valid/ready port.
//   state  | meaning
//   IDLE   | waiting for START, all outputs low
//   REQ    | read strobe for current row
//   WAIT   | read latency, word captured at end of cycle
//   STREAM | emitting columns 0..N-1 of the captured word
//   FIN    | DONE (and ERR for bad shape) pulse
module outmem_reader
  import outmem_pkg::*;
(
  input logic CLK,
  input logic RST,
  outmem_reader_if.master bus
);

  state_t            state_q, state_d;
  logic [FLD_W-1:0]  m_q, m_d;
  logic [FLD_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [FLD_W-1:0]  col_q, col_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] lane_data;
  logic              last_col;
  logic              last_row;
  logic              unused_mnt_lo;

  assign unused_mnt_lo = ^bus.MNT[MNT_N_LO-1:0];

  outmem_lane_mux u_lane_mux (
    .word_i (word_q),
    .sel_i  (col_q[SEL_W-1:0]),
    .data_o (lane_data)
  );

  assign last_col = (col_q == (n_q - FLD_W'(1)));
  assign last_row = (row_q == (m_q - ADDR_W'(1)));

  assign bus.BUSY = (state_q != ST_IDLE);
  assign bus.RW_O = RW_READ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    n_d           = n_q;
    row_d         = row_q;
    col_d         = col_q;
    err_d         = err_q;
    word_d        = word_q;
    bus.EN_O      = 1'b0;
    bus.ADDR_O    = '0;
    bus.OUT_VALID = 1'b0;
    bus.OUT_DATA  = '0;
    bus.OUT_LAST  = 1'b0;
    bus.DONE      = 1'b0;
    bus.ERR       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          m_d     = bus.MNT[MNT_M_HI:MNT_M_LO];
          n_d     = bus.MNT[MNT_N_HI:MNT_N_LO];
          row_d   = '0;
          col_d   = '0;
          err_d   = shape_invalid(m_d, n_d);
          state_d = err_d ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        bus.EN_O   = 1'b1;
        bus.ADDR_O = row_q;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        word_d  = bus.RDATA_O;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        bus.OUT_VALID = 1'b1;
        bus.OUT_DATA  = lane_data;
        bus.OUT_LAST  = last_col && last_row;
        if (bus.OUT_READY) begin
          if (!last_col) begin
            col_d = col_q + FLD_W'(1);
          end else if (!last_row) begin
            row_d   = row_q + ADDR_W'(1);
            col_d   = '0;
            state_d = ST_REQ;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        bus.DONE = 1'b1;
        bus.ERR  = err_q;
        err_d    = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_outmem_reader.sv
// Self-checking bench for outmem_reader: vector table of shapes/ready patterns
// with a scoreboard of expected elements and addresses, plus reset/idle sequences.
module tb_outmem_reader;
  import outmem_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  outmem_reader_if bus();

  outmem_reader dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  logic [63:0] mem [16];

  always @(posedge CLK) begin
    if (bus.EN_O) bus.RDATA_O <= mem[bus.ADDR_O];
  end

  typedef struct {
    logic [11:0] mnt;
    int          fill;
    int          rdy;
    bit          busy_start;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } elem_t;

  elem_t       exp_q[$];
  logic [3:0]  addr_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_of(input logic [63:0] w, input int c);
    logic [63:0] t;
    t = w >> (48 - 16 * c);
    return t[15:0];
  endfunction

  function automatic logic rdy_fn(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic fill_mem(input int kind);
    for (int i = 0; i < 16; i++) begin
      if (kind == 0)
        mem[i] = {16'(4*i+1), 16'(4*i+2), 16'(4*i+3), 16'(4*i+4)};
      else
        mem[i] = 64'h00AA_00BB_00CC_00DD;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  bus.BUSY, 0);
    check({tag, "_en"},    bus.EN_O, 0);
    check({tag, "_addr"},  bus.ADDR_O, 0);
    check({tag, "_valid"}, bus.OUT_VALID, 0);
    check({tag, "_data"},  bus.OUT_DATA, 0);
    check({tag, "_last"},  bus.OUT_LAST, 0);
    check({tag, "_done"},  bus.DONE, 0);
    check({tag, "_err"},   bus.ERR, 0);
    check({tag, "_rw"},    bus.RW_O, 0);
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v);
    int          m, n, cyc, done_cyc, last_hs, first_en, first_valid;
    bit          done_seen, held, held_last;
    logic [15:0] held_data;
    elem_t       e;

    fill_mem(v.fill);
    exp_q.delete();
    addr_q.delete();
    m = int'(v.mnt[11:8]);
    n = int'(v.mnt[7:4]);
    if (!v.exp_err) begin
      for (int r = 0; r < m; r++) begin
        addr_q.push_back(4'(r));
        for (int c = 0; c < n; c++) begin
          e.data = lane_of(mem[r], c);
          e.last = (r == m - 1) && (c == n - 1);
          exp_q.push_back(e);
        end
      end
    end

    bus.MNT       = v.mnt;
    bus.START     = 1'b1;
    @(posedge CLK);
    #1;
    bus.START     = 1'b0;
    bus.MNT       = 12'hFFF;
    bus.OUT_READY = rdy_fn(v.rdy, 1);

    cyc = 0; done_cyc = -1; last_hs = -1; first_en = -1; first_valid = -1;
    done_seen = 0; held = 0; held_last = 0; held_data = '0;
    while (cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (done_seen && cyc == done_cyc + 1) begin
        check("busy_after_done", bus.BUSY, 0);
        check("done_one_cycle", bus.DONE, 0);
        break;
      end
      check("rw_zero", bus.RW_O, 0);
      if (v.exp_err) begin
        check("no_en_on_err", bus.EN_O, 0);
        check("no_valid_on_err", bus.OUT_VALID, 0);
      end else if (bus.EN_O) begin
        if (first_en < 0) begin
          first_en = cyc;
          check("en_latency", first_en, 1);
        end
        check("addr_sb_nonempty", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("read_addr", bus.ADDR_O, addr_q.pop_front());
      end
      if (held) begin
        check("stall_valid", bus.OUT_VALID, 1);
        check("stall_data", bus.OUT_DATA, held_data);
        check("stall_last", bus.OUT_LAST, held_last);
      end
      held = 0;
      if (bus.OUT_VALID) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          check("valid_latency", first_valid, 3);
        end
        if (bus.OUT_READY) begin
          check("elem_sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", bus.OUT_DATA, e.data);
            check("out_last", bus.OUT_LAST, e.last);
          end
          last_hs = cyc;
        end else begin
          held = 1; held_data = bus.OUT_DATA; held_last = bus.OUT_LAST;
        end
      end
      if (bus.DONE) begin
        done_seen = 1;
        done_cyc  = cyc;
        check("err_flag", bus.ERR, v.exp_err);
        check("busy_in_fin", bus.BUSY, 1);
        check("elems_drained", exp_q.size(), 0);
        check("addrs_drained", addr_q.size(), 0);
        if (v.exp_err) check("err_done_cycle", done_cyc, 1);
        else           check("done_after_last", done_cyc, last_hs + 1);
      end else if (!done_seen) begin
        check("busy_during_run", bus.BUSY, 1);
      end
      @(posedge CLK);
      #1;
      bus.OUT_READY = rdy_fn(v.rdy, cyc + 1);
      if (v.busy_start && (cyc + 1 == 4 || done_cyc == cyc)) begin
        bus.START = 1'b1;
        bus.MNT   = 12'h110;
      end else begin
        bus.START = 1'b0;
        bus.MNT   = 12'hFFF;
      end
    end
    check("done_seen", done_seen, 1);
    bus.START = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t rv;

    vecs[0] = '{12'h240, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{12'h240, 0, 1, 1'b0, 1'b0};
    vecs[2] = '{12'h320, 1, 0, 1'b0, 1'b0};
    vecs[3] = '{12'h050, 0, 0, 1'b0, 1'b1};
    vecs[4] = '{12'h250, 0, 0, 1'b0, 1'b1};
    vecs[5] = '{12'h200, 0, 0, 1'b0, 1'b1};
    vecs[6] = '{12'h240, 0, 0, 1'b1, 1'b0};
    vecs[7] = '{12'hF10, 0, 2, 1'b0, 1'b0};
    vecs[8] = '{12'h43F, 0, 2, 1'b1, 1'b0};
    vecs[9] = '{12'h110, 1, 1, 1'b0, 1'b0};

    RST           = 1'b1;
    bus.START     = 1'b0;
    bus.MNT       = '0;
    bus.OUT_READY = 1'b0;
    bus.RDATA_O   = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_idle("reset");
    @(posedge CLK);
    #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during STREAM of row 1, then restart from address 0.
    fill_mem(0);
    bus.MNT       = 12'h240;
    bus.OUT_READY = 1'b1;
    bus.START     = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    check("mid_row1_valid", bus.OUT_VALID, 1);
    check("mid_row1_data", bus.OUT_DATA, 16'h0005);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_idle("midreset");
    @(posedge CLK);
    #1;
    rv = '{12'h140, 0, 0, 1'b0, 1'b0};
    run_vec(rv);

    @(negedge CLK);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
